shift_exec_stage: RTL
=====================

# shift_exec_stage

Two-stage pipelined shift execution stage for the rv32i core. It sits directly upstream of the combinational `sll` barrel shifter and its `srl`/`sra` siblings. It accepts decoded shift micro-ops over a valid/ready handshake, extracts the shift amount, and drives the shifters from registered operands. The selected result, with its destination register tag, goes to writeback over a second valid/ready handshake. It also keeps a saturating count of retired shift ops for the performance counters.

## Interface
Parameters:
- `N`, 32, datapath width; must be a power of two ≥ 2.
- `CNT_W`, 16, width of the retired-op counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- `in_valid`  in  1  upstream op valid.
- `in_ready`  out  1  stage can accept an op this cycle.
- `in_op`  in  2  `shift_op_t`: SLL=0, SRL=1, SRA=2, RSVD=3.
- `in_a`  in  N  value to shift.
- `in_b`  in  N  shift-amount source (rs2 or immediate); only bits [$clog2(N)-1:0] are used.
- `in_rd`  in  5  destination register tag, passed through unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_result`  out  N  shifted value.
- `out_rd`  out  5  tag of `out_result`.
- `out_illegal`  out  1  op was RSVD.
- `op_count`  out  CNT_W  number of retired ops, saturating.

## Operation
- **S1 (operand register).** Holds `op`, `a`, `shamt = in_b[$clog2(N)-1:0]`, `rd` and `s1_valid`. Upper `in_b` bits are discarded.
- **S2 (result register).** Holds `result`, `rd`, `illegal` and `s2_valid`.
- **S1 to S2 path.** `shift_core` computes the shift combinationally from the S1 registers:
  - SLL: `a << shamt`, zero fill.
  - SRL: `a >> shamt`, zero fill.
  - SRA: `a >>> shamt`, sign fill from `a[N-1]`.
  - RSVD: result 0 and `illegal=1`.
- **Control:**
  - `adv2 = s2_valid & out_ready`
  - `adv1 = s1_valid & (~s2_valid | out_ready)`
  - `in_ready = ~s1_valid | adv1`, combinational from `out_ready` and state.
- **Acceptance.** An op is accepted when `in_valid & in_ready`. S1 loads the new op; otherwise S1 clears its valid if `adv1`.
- **S2 update.**
  - If `adv1`, S2 loads from S1.
  - Else if `adv2`, `s2_valid` clears.
  - Otherwise S2 holds.
- **Output stability.** While `out_valid & ~out_ready`, `out_result`, `out_rd` and `out_illegal` are held stable.
- **Counter.** `op_count` increments by 1 on each `adv2`, RSVD ops included. It saturates at 2^CNT_W−1 and does not wrap.
- **Reset.** Asynchronous, at any time including mid-stall. Clears both valids, all data registers and `op_count` to 0, discarding in-flight ops. After reset `in_ready=1` and `out_valid=0`.

## Timing
- **Latency.** An op accepted at edge k appears with `out_valid=1` after edge k+1 when there is no stall, i.e. 2 register stages.
- **Throughput.** 1 op/cycle with `out_ready` held high. No bubbles are inserted.
- **Backpressure.** With `out_ready=0`, the stage accepts at most 2 ops (S1 and S2 full) and then drops `in_ready`.
  - When `out_ready` rises with both stages full, S2 retires, S1 moves to S2 and a new op is accepted, all in the same cycle.
- **Input stability.** `in_*` may change freely when `in_valid=0`. Upstream holds `in_*` stable while `in_valid & ~in_ready`.
- **Critical path.** The combinational path in the stage is the S1 → `shift_core` → S2 data path. No input-to-output data path is combinational.

## Structure
- **`shift_pkg`.** Holds `typedef enum logic [1:0] shift_op_t` (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_RSVD).
- **`shift_core` sub-module.** Purely combinational. Instantiates the existing `sll`, `srl`, `sra` with `.N(N)`, selects by op, and generates the illegal flag.
- **Top level.** `shift_exec_stage` contains only the two register stages, the handshake logic and the counter.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with both stages full → `out_valid=0`, `in_ready=1`, `op_count=0` immediately (asynchronous). Nothing from the old ops emerges after release.
- **Basic ops:** `a=32'h8000_0001`, `b=32'hFFFF_FFE4` (shamt=4):
  - SLL → `32'h0000_0010`.
  - SRL → `32'h0800_0000`.
  - SRA → `32'hF800_0000`.
  - Each arrives 2 cycles after acceptance with the correct `out_rd`.
- **Boundary shamt:**
  - shamt=0 → result equals `a`.
  - shamt=31 with SRA of `32'h8000_0000` → `32'hFFFF_FFFF`.
  - shamt=31 with SLL of `32'h0000_0001` → `32'h8000_0000`.
- **RSVD op:** RSVD op with rd=7 → `out_result=0`, `out_illegal=1`, `out_rd=7`, and `op_count` increments.
- **Backpressure:**
  - Stream 5 ops with `out_ready=0` → exactly 2 accepted, `in_ready=0`, outputs stable.
  - Release `out_ready` → all 5 retire in order, one per cycle, no loss or duplication.
- **Saturation:** with `CNT_W=4`, retire 20 ops → `op_count` stops at 15.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shift micro-op encoding shared by the shift execution stage and its core
package shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'd0,
    SHIFT_SRL  = 2'd1,
    SHIFT_SRA  = 2'd2,
    SHIFT_RSVD = 2'd3
  } shift_op_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational op select over sll/srl/sra; op,a,shamt -> result, illegal (RSVD gives 0)
module shift_core
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  shift_op_t            op,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         result,
  output logic                 illegal
);
  logic [N-1:0] sll_y, srl_y, sra_y;
  sll #(.N(N)) u_sll (.a(a), .shamt(shamt), .y(sll_y));
  srl #(.N(N)) u_srl (.a(a), .shamt(shamt), .y(srl_y));
  sra #(.N(N)) u_sra (.a(a), .shamt(shamt), .y(sra_y));
  always_comb begin
    result  = op == SHIFT_SLL ? sll_y :
              op == SHIFT_SRL ? srl_y :
              op == SHIFT_SRA ? sra_y : '0;
    illegal = op == SHIFT_RSVD;
  end
endmodule

// File: rtl/sll.sv
// sll: combinational logical left barrel shifter; a by shamt -> y, zero fill
module sll #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = a << shamt;
endmodule

// File: rtl/sra.sv
// sra: combinational arithmetic right barrel shifter; a by shamt -> y, sign fill from a[N-1]
module sra #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = $signed(a) >>> shamt;
endmodule

// File: rtl/srl.sv
// srl: combinational logical right barrel shifter; a by shamt -> y, zero fill
module srl #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = a >> shamt;
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage shift pipeline; in_* valid/ready in, out_* valid/ready to writeback, op_count saturating retire count
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);
  localparam int SW = $clog2(N);
  logic           s1_valid, s2_valid, adv1, adv2, accept, core_illegal, s2_illegal;
  shift_op_t      s1_op;
  logic [N-1:0]   s1_a, s2_result, core_result;
  logic [SW-1:0]  s1_shamt;
  logic [4:0]     s1_rd, s2_rd;
  assign adv2        = s2_valid & out_ready;
  assign adv1        = s1_valid & (~s2_valid | out_ready);
  assign in_ready    = ~s1_valid | adv1;
  assign accept      = in_valid & in_ready;
  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_rd      = s2_rd;
  assign out_illegal = s2_illegal;
  shift_core #(.N(N)) u_core (
    .op(s1_op), .a(s1_a), .shamt(s1_shamt), .result(core_result), .illegal(core_illegal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= SHIFT_SLL;
      s1_a       <= '0;
      s1_shamt   <= '0;
      s1_rd      <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= shift_op_t'(in_op);
        s1_a     <= in_a;
        s1_shamt <= in_b[SW-1:0];
        s1_rd    <= in_rd;
      end else if (adv1) s1_valid <= 1'b0;
      if (adv1) begin
        s2_valid   <= 1'b1;
        s2_result  <= core_result;
        s2_rd      <= s1_rd;
        s2_illegal <= core_illegal;
      end else if (adv2) s2_valid <= 1'b0;
      if (adv2 && !(&op_count)) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule
